// File: rtl/alu_mul_seq.sv
// Sequential shift-and-add multiplier that time-shares an external WIDTH-bit ALU adder.
// Optional build macro MUL_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are zero.
module alu_mul_seq #(
  parameter int          WIDTH   = 4,
  parameter logic [2:0]  OP_ADD  = 3'b010,
  parameter logic [2:0]  OP_IDLE = 3'b000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2:0]           alu_op,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  input  logic [WIDTH-1:0]     alu_s,
  input  logic                 alu_cout,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int PW    = 2 * WIDTH;

  // Handshake: start is sampled only while IDLE; busy covers ADD and DONE;
  // done is a one-cycle pulse with product already valid in that cycle.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [CNT_W-1:0]   r_count;
  logic [PW-1:0]      r_product;
  logic [PW-1:0]      w_step;
  logic [PW-1:0]      w_final;
  logic               w_last;

  // One shift-and-add step: the ALU carry becomes the new top bit of hi.
  assign w_step = {alu_cout, alu_s, r_lo[WIDTH-1:1]};

`ifdef MUL_EARLY_EXIT_EN
  logic [CNT_W-1:0]   w_rem;
  logic [WIDTH-1:0]   w_rem_mask;
  logic               w_rem_zero;

  // After this edge, lo[WIDTH-1-count:1] still holds unprocessed multiplier bits.
  assign w_rem      = CNT_W'(WIDTH - 1) - r_count;
  assign w_rem_mask = (WIDTH'(1) << w_rem) - WIDTH'(1);
  assign w_rem_zero = ((r_lo >> 1) & w_rem_mask) == '0;
  assign w_last     = (r_count == CNT_W'(WIDTH - 1)) || w_rem_zero;
  assign w_final    = w_step >> w_rem;
`else
  assign w_last     = (r_count == CNT_W'(WIDTH - 1));
  assign w_final    = w_step;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    alu_op      = OP_IDLE;
    alu_a       = '0;
    alu_b       = '0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_ADD;
        end
      end
      S_ADD: begin
        alu_op = OP_ADD;
        alu_a  = r_hi;
        alu_b  = r_lo[0] ? r_mcand : '0;
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mcand   <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_count   <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mcand <= a;
            r_lo    <= b;
            r_hi    <= '0;
            r_count <= '0;
          end
        end
        S_ADD: begin
          // The count is left alone on the final step so it never wraps.
          if (w_last) begin
            {r_hi, r_lo} <= w_final;
            r_product    <= w_final;
          end else begin
            {r_hi, r_lo} <= w_step;
            r_count      <= r_count + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy    = (r_state != S_IDLE);
  assign done    = (r_state == S_DONE);
  assign product = r_product;

endmodule
